instr_issue: RTL and testbench

Instruction issue unit that drives the 32-bit instruction input of the `Pipeline` core, replacing the hand-sequenced stimulus used so far. A host pushes instructions into an internal FIFO through a valid/ready handshake. The unit presents each instruction to the core for exactly `HOLD` clock cycles, so the three-stage datapath sees every instruction long enough to complete without hazard logic. When no instruction is queued, it drives a configurable idle instruction.

---
 rtl/instr_issue_if.sv | 29 ++
 rtl/instr_issue.sv | 147 ++++++++++++++
 tb/tb_instr_issue.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/instr_issue_if.sv
// ---------------------------------------------------------------------------
// instr_issue_if : host-side and core-side signal bundle of the instruction
// issue unit.
//   master : host/environment side. It drives flush, in_valid and in_instr and
//            observes in_ready, instr_out, instr_valid, count and busy.
//   slave  : the issue unit itself.
// ---------------------------------------------------------------------------
interface instr_issue_if #(
   parameter int DEPTH = 8
);
   logic                      flush;
   logic                      in_valid;
   logic [31:0]               in_instr;
   logic                      in_ready;
   logic [31:0]               instr_out;
   logic                      instr_valid;
   logic [$clog2(DEPTH):0]    count;
   logic                      busy;

   modport master (
      output flush, in_valid, in_instr,
      input  in_ready, instr_out, instr_valid, count, busy
   );

   modport slave (
      input  flush, in_valid, in_instr,
      output in_ready, instr_out, instr_valid, count, busy
   );
endinterface

// File: rtl/instr_issue.sv
// ---------------------------------------------------------------------------
// instr_issue : queues host instructions in a FIFO and presents each one to
// the core for exactly HOLD cycles. When nothing is queued, it drives
// IDLE_INSTR.
// Ports:
//   clk  - system clock (rising edge)
//   rst  - asynchronous active-high reset
//   bus  - instr_issue_if.slave:
//            flush        synchronous clear of the queue and of the current issue
//            in_valid     host handshake: word offered
//            in_instr     host handshake: word
//            in_ready     host handshake: queue not full
//            instr_out    registered word to the core
//            instr_valid  instr_out holds a real instruction
//            count        queued words, excluding the one being issued
//            busy         count != 0 or instr_valid
// ---------------------------------------------------------------------------
module instr_issue #(
   parameter int          DEPTH      = 8,
   parameter int          HOLD       = 3,
   parameter logic [31:0] IDLE_INSTR = 32'hFC00_0000
) (
   input  logic            clk,
   input  logic            rst,
   instr_issue_if.slave    bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } state_t;

   logic [31:0]   mem_r [DEPTH];
   logic [AW-1:0] wptr_r;
   logic [AW-1:0] rptr_r;
   logic [CW-1:0] count_r;
   logic [3:0]    hcnt_r;
   state_t        state_r;
   logic [31:0]   instr_out_r;
   logic          instr_valid_r;

   logic          in_ready_s;
   logic          push_s;
   logic          pop_s;
   state_t        state_nx_s;
   logic [3:0]    hcnt_nx_s;
   logic [31:0]   instr_out_nx_s;
   logic          instr_valid_nx_s;

   // Handshake qualification. Full blocks the push even if a pop happens on the same edge.
   always_comb begin
      in_ready_s = (count_r != CW'(DEPTH));
      push_s     = bus.in_valid & in_ready_s & ~bus.flush;
   end

   // Issue state machine: next state, hold counter, next output word and the pop request.
   always_comb begin
      state_nx_s       = state_r;
      hcnt_nx_s        = hcnt_r;
      instr_out_nx_s   = instr_out_r;
      instr_valid_nx_s = instr_valid_r;
      pop_s            = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (count_r != {CW{1'b0}}) begin
               pop_s            = 1'b1;
               instr_out_nx_s   = mem_r[rptr_r];
               instr_valid_nx_s = 1'b1;
               hcnt_nx_s        = 4'(HOLD - 1);
               state_nx_s       = ST_ISSUE;
            end else begin
               instr_out_nx_s   = IDLE_INSTR;
               instr_valid_nx_s = 1'b0;
            end
         end
         ST_ISSUE: begin
            if (hcnt_r != 4'd0) begin
               hcnt_nx_s = hcnt_r - 4'd1;
            end else if (count_r != {CW{1'b0}}) begin
               // back-to-back issue: no idle cycle between words
               pop_s            = 1'b1;
               instr_out_nx_s   = mem_r[rptr_r];
               instr_valid_nx_s = 1'b1;
               hcnt_nx_s        = 4'(HOLD - 1);
            end else begin
               instr_out_nx_s   = IDLE_INSTR;
               instr_valid_nx_s = 1'b0;
               state_nx_s       = ST_IDLE;
            end
         end
         default: begin
            instr_out_nx_s   = IDLE_INSTR;
            instr_valid_nx_s = 1'b0;
            hcnt_nx_s        = 4'd0;
            state_nx_s       = ST_IDLE;
         end
      endcase
   end

   // FIFO storage write. The data array needs no reset because count guards every read.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wptr_r] <= bus.in_instr;
      end
   end

   // Control state: pointers, occupancy, FSM and registered outputs. A flush overrides everything except rst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_r        <= {AW{1'b0}};
         rptr_r        <= {AW{1'b0}};
         count_r       <= {CW{1'b0}};
         hcnt_r        <= 4'd0;
         state_r       <= ST_IDLE;
         instr_out_r   <= IDLE_INSTR;
         instr_valid_r <= 1'b0;
      end else if (bus.flush) begin
         wptr_r        <= {AW{1'b0}};
         rptr_r        <= {AW{1'b0}};
         count_r       <= {CW{1'b0}};
         hcnt_r        <= 4'd0;
         state_r       <= ST_IDLE;
         instr_out_r   <= IDLE_INSTR;
         instr_valid_r <= 1'b0;
      end else begin
         // pointers wrap naturally modulo DEPTH (power of two)
         wptr_r        <= wptr_r + AW'(push_s);
         rptr_r        <= rptr_r + AW'(pop_s);
         count_r       <= count_r + CW'(push_s) - CW'(pop_s);
         hcnt_r        <= hcnt_nx_s;
         state_r       <= state_nx_s;
         instr_out_r   <= instr_out_nx_s;
         instr_valid_r <= instr_valid_nx_s;
      end
   end

   // Output drive: in_ready and busy are derived from registered state only.
   always_comb begin
      bus.in_ready    = in_ready_s;
      bus.instr_out   = instr_out_r;
      bus.instr_valid = instr_valid_r;
      bus.count       = count_r;
      bus.busy        = (count_r != {CW{1'b0}}) | instr_valid_r;
   end
endmodule

// File: tb/tb_instr_issue.sv
// ---------------------------------------------------------------------------
// tb_instr_issue : two instances with the same stimulus, one with HOLD=3 and
// one with HOLD=1, compared every cycle against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_instr_issue;
   localparam logic [31:0] IDLE = 32'hFC00_0000;
   localparam int          DEP  = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   instr_issue_if #(.DEPTH(DEP)) ifc0 ();
   instr_issue_if #(.DEPTH(DEP)) ifc1 ();

   instr_issue #(.DEPTH(DEP), .HOLD(3), .IDLE_INSTR(IDLE)) dut0 (
      .clk (clk), .rst (rst), .bus (ifc0.slave));
   instr_issue #(.DEPTH(DEP), .HOLD(1), .IDLE_INSTR(IDLE)) dut1 (
      .clk (clk), .rst (rst), .bus (ifc1.slave));

   int total = 0;
   int bad   = 0;

   // reference model: a queue per instance, plus the word being shown and how many cycles it has left
   logic [31:0] mq [2][$];
   logic [31:0] mout [2];
   logic        mv [2];
   int          mleft [2];
   int          hold_of [2] = '{3, 1};
   int          peak;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         mq[k].delete();
         mout[k]  = IDLE;
         mv[k]    = 1'b0;
         mleft[k] = 0;
      end
   endtask

   // One rising edge under the rules: decisions use the queue size seen before the edge.
   task automatic model_step(input logic v, input logic [31:0] w, input logic fl);
      for (int k = 0; k < 2; k++) begin
         int sz;
         sz = mq[k].size();
         if (fl) begin
            mq[k].delete();
            mout[k] = IDLE; mv[k] = 1'b0; mleft[k] = 0;
         end else begin
            if (mv[k] && mleft[k] > 1) mleft[k]--;
            else if (sz > 0) begin
               mout[k] = mq[k].pop_front(); mv[k] = 1'b1; mleft[k] = hold_of[k];
            end else begin
               mout[k] = IDLE; mv[k] = 1'b0; mleft[k] = 0;
            end
            if (v && sz < DEP) mq[k].push_back(w);
         end
      end
   endtask

   task automatic compare_all();
      check_eq("h3.instr_out",   ifc0.instr_out,          mout[0]);
      check_eq("h3.instr_valid", 32'(ifc0.instr_valid),   32'(mv[0]));
      check_eq("h3.count",       32'(ifc0.count),         32'(mq[0].size()));
      check_eq("h3.in_ready",    32'(ifc0.in_ready),      32'(mq[0].size() != DEP));
      check_eq("h3.busy",        32'(ifc0.busy),          32'(mq[0].size() != 0 || mv[0]));
      check_eq("h1.instr_out",   ifc1.instr_out,          mout[1]);
      check_eq("h1.instr_valid", 32'(ifc1.instr_valid),   32'(mv[1]));
      check_eq("h1.count",       32'(ifc1.count),         32'(mq[1].size()));
      check_eq("h1.in_ready",    32'(ifc1.in_ready),      32'(mq[1].size() != DEP));
      check_eq("h1.busy",        32'(ifc1.busy),          32'(mq[1].size() != 0 || mv[1]));
   endtask

   // Drive inputs at the falling edge, advance the model at the rising edge, then compare 1 time unit later.
   task automatic cycle(input logic v, input logic [31:0] w, input logic fl);
      @(negedge clk);
      ifc0.in_valid = v; ifc0.in_instr = w; ifc0.flush = fl;
      ifc1.in_valid = v; ifc1.in_instr = w; ifc1.flush = fl;
      @(posedge clk);
      model_step(v, w, fl);
      #1;
      compare_all();
      if (int'(ifc0.count) > peak) peak = int'(ifc0.count);
   endtask

   initial begin
      ifc0.in_valid = 1'b0; ifc0.in_instr = 32'd0; ifc0.flush = 1'b0;
      ifc1.in_valid = 1'b0; ifc1.in_instr = 32'd0; ifc1.flush = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare_all();
      @(negedge clk);
      rst = 1'b0;

      // single word: shown for three edges, then idle
      cycle(1'b1, 32'h0021_0000, 1'b0);
      for (int i = 0; i < 5; i++) cycle(1'b0, 32'd0, 1'b0);

      // three back-to-back words
      peak = 0;
      cycle(1'b1, 32'h0021_0000, 1'b0);
      cycle(1'b1, 32'h07C1_0000, 1'b0);
      cycle(1'b1, 32'h0C22_0000, 1'b0);
      for (int i = 0; i < 10; i++) cycle(1'b0, 32'd0, 1'b0);
      check_eq("peak_count", 32'(peak), 32'd2);

      // fill: in_valid kept high long enough to saturate the queue and wrap the pointers
      peak = 0;
      for (int i = 0; i < 70; i++) cycle(1'b1, $urandom, 1'b0);
      check_eq("full_peak", 32'(peak), 32'(DEP));
      for (int i = 0; i < 30; i++) cycle(1'b0, 32'd0, 1'b0);

      // flush mid-hold with at least 3 queued and a push on the same edge
      for (int i = 0; i < 6; i++) cycle(1'b1, $urandom, 1'b0);
      check_eq("pre_flush_q", 32'(ifc0.count >= 3), 32'd1);
      cycle(1'b1, 32'hDEAD_BEEF, 1'b1);
      check_eq("flush_out", ifc0.instr_out, IDLE);
      for (int i = 0; i < 10; i++) cycle(1'b0, 32'd0, 1'b0);

      // random traffic with occasional flush
      for (int i = 0; i < 400; i++)
         cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 39) == 0);

      // asynchronous reset between edges while issuing
      cycle(1'b1, 32'h1111_0000, 1'b0);
      cycle(1'b1, 32'h2222_0000, 1'b0);
      cycle(1'b0, 32'd0, 1'b0);
      check_eq("pre_rst_valid", 32'(ifc0.instr_valid), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      compare_all();
      @(negedge clk);
      rst = 1'b0;
      ifc0.in_valid = 1'b0; ifc1.in_valid = 1'b0;
      ifc0.flush = 1'b0; ifc1.flush = 1'b0;
      cycle(1'b1, 32'h3333_0000, 1'b0);
      cycle(1'b0, 32'd0, 1'b0);
      check_eq("post_rst_lat", ifc0.instr_out, 32'h3333_0000);
      for (int i = 0; i < 6; i++) cycle(1'b0, 32'd0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
